// File: rtl/tbb_mixer_dac.sv
// TBB1143 output stage: per-channel volume, 6-bit mix, and a 1-bit DAC
// (first-order sigma-delta or 64-step PWM) for an off-chip RC filter.
module tbb_mixer_dac #(
  parameter logic [3:0] VOL_RESET  = 4'hF,
  parameter logic [3:0] CTRL_RESET = 4'b0001
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sample_en_i,
  input  logic       sq0_i,
  input  logic       sq1_i,
  input  logic [3:0] tri_i,
  input  logic       cfg_wr_i,
  input  logic [1:0] cfg_addr_i,
  input  logic [3:0] cfg_d_i,
  output logic [5:0] mix_o,
  output logic       dac_out_o
);

  localparam logic [1:0] ADDR_VOL0 = 2'd0;
  localparam logic [1:0] ADDR_VOL1 = 2'd1;
  localparam logic [1:0] ADDR_VOLT = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  logic [3:0] vol0_q, vol0_d;
  logic [3:0] vol1_q, vol1_d;
  logic [3:0] volt_q, volt_d;
  // ctrl[0] = EN, ctrl[1] = MODE (1 = PWM); reserved bits are not stored
  logic [1:0] ctrl_q, ctrl_d;

  logic       s1_vld_q, s1_vld_d;
  logic       sq0_s1_q, sq0_s1_d;
  logic       sq1_s1_q, sq1_s1_d;
  logic [3:0] tri_s1_q, tri_s1_d;
  logic [3:0] vol0_s1_q, vol0_s1_d;
  logic [3:0] vol1_s1_q, vol1_s1_d;
  logic [3:0] volt_s1_q, volt_s1_d;

  logic [5:0] mix_q, mix_d;
  logic [5:0] acc_q, acc_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] lvl_q, lvl_d;
  logic       dac_q, dac_d;

  logic [7:0] tri_prod;
  logic [5:0] mix_sum;
  logic [6:0] sum7;
  logic       ctrl_chg;

  always_comb begin
    vol0_d = vol0_q;
    vol1_d = vol1_q;
    volt_d = volt_q;
    ctrl_d = ctrl_q;
    if (cfg_wr_i) begin
      case (cfg_addr_i)
        ADDR_VOL0: vol0_d = cfg_d_i;
        ADDR_VOL1: vol1_d = cfg_d_i;
        ADDR_VOLT: volt_d = cfg_d_i;
        ADDR_CTRL: ctrl_d = cfg_d_i[1:0];
        default:   ctrl_d = ctrl_q;
      endcase
    end
  end

  // Stage 1 snapshots the pre-write volumes so a same-cycle write misses this sample
  always_comb begin
    s1_vld_d  = sample_en_i;
    sq0_s1_d  = sq0_s1_q;
    sq1_s1_d  = sq1_s1_q;
    tri_s1_d  = tri_s1_q;
    vol0_s1_d = vol0_s1_q;
    vol1_s1_d = vol1_s1_q;
    volt_s1_d = volt_s1_q;
    if (sample_en_i) begin
      sq0_s1_d  = sq0_i;
      sq1_s1_d  = sq1_i;
      tri_s1_d  = tri_i;
      vol0_s1_d = vol0_q;
      vol1_s1_d = vol1_q;
      volt_s1_d = volt_q;
    end
  end

  always_comb begin
    tri_prod = {4'b0000, tri_s1_q} * {4'b0000, volt_s1_q};
    mix_sum  = {2'b00, (sq0_s1_q ? vol0_s1_q : 4'd0)}
             + {2'b00, (sq1_s1_q ? vol1_s1_q : 4'd0)}
             + {2'b00, tri_prod[7:4]};
    mix_d    = s1_vld_q ? mix_sum : mix_q;
  end

  // A CTRL write that alters EN or MODE restarts the modulator from zero
  always_comb begin
    ctrl_chg = cfg_wr_i && (cfg_addr_i == ADDR_CTRL) && (cfg_d_i[1:0] != ctrl_q);
    sum7     = {1'b0, acc_q} + {1'b0, mix_q};
    acc_d    = 6'd0;
    cnt_d    = 6'd0;
    lvl_d    = 6'd0;
    dac_d    = 1'b0;
    if (!ctrl_chg && ctrl_q[0]) begin
      if (!ctrl_q[1]) begin
        acc_d = sum7[5:0];
        dac_d = sum7[6];
      end else begin
        dac_d = (cnt_q < lvl_q);
        lvl_d = (cnt_q == 6'd63) ? mix_q : lvl_q;
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vol0_q    <= VOL_RESET;
      vol1_q    <= VOL_RESET;
      volt_q    <= VOL_RESET;
      ctrl_q    <= CTRL_RESET[1:0];
      s1_vld_q  <= 1'b0;
      sq0_s1_q  <= 1'b0;
      sq1_s1_q  <= 1'b0;
      tri_s1_q  <= 4'd0;
      vol0_s1_q <= 4'd0;
      vol1_s1_q <= 4'd0;
      volt_s1_q <= 4'd0;
      mix_q     <= 6'd0;
      acc_q     <= 6'd0;
      cnt_q     <= 6'd0;
      lvl_q     <= 6'd0;
      dac_q     <= 1'b0;
    end else begin
      vol0_q    <= vol0_d;
      vol1_q    <= vol1_d;
      volt_q    <= volt_d;
      ctrl_q    <= ctrl_d;
      s1_vld_q  <= s1_vld_d;
      sq0_s1_q  <= sq0_s1_d;
      sq1_s1_q  <= sq1_s1_d;
      tri_s1_q  <= tri_s1_d;
      vol0_s1_q <= vol0_s1_d;
      vol1_s1_q <= vol1_s1_d;
      volt_s1_q <= volt_s1_d;
      mix_q     <= mix_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      dac_q     <= dac_d;
    end
  end

  assign mix_o     = mix_q;
  assign dac_out_o = dac_q;

endmodule

// File: tb/tb_tbb_mixer_dac.sv
// Bench for tbb_mixer_dac: arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tbb_mixer_dac;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic       sq0, sq1;
  logic [3:0] tri_in;
  logic       cfg_wr;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_d;
  logic [5:0] mix;
  logic       dac;

  int total = 0;
  int bad   = 0;

  tbb_mixer_dac dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sample_en_i (sample_en),
    .sq0_i       (sq0),
    .sq1_i       (sq1),
    .tri_i       (tri_in),
    .cfg_wr_i    (cfg_wr),
    .cfg_addr_i  (cfg_addr),
    .cfg_d_i     (cfg_d),
    .mix_o       (mix),
    .dac_out_o   (dac)
  );

  always #5 clk = ~clk;

  // Reference model: sample results travel as (value, due-cycle) pairs
  int m_vol[3];
  int m_ctrl, m_mix, m_acc, m_cnt, m_lvl, m_dac;
  int m_on = 0;
  int cyc  = 0;
  int q_val[$];
  int q_due[$];

  always @(posedge clk) begin
    int nmix, s;
    bit chg;
    cyc++;
    if (rst) begin
      m_vol[0] = 15; m_vol[1] = 15; m_vol[2] = 15;
      m_ctrl = 1; m_mix = 0; m_acc = 0; m_cnt = 0; m_lvl = 0; m_dac = 0;
      q_val.delete(); q_due.delete();
      m_on = 1;
    end else begin
      nmix = m_mix;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        nmix = q_val.pop_front();
        void'(q_due.pop_front());
      end
      chg = cfg_wr && cfg_addr == 2'd3 && (int'(cfg_d) % 4) != m_ctrl;
      if (chg || (m_ctrl % 2) == 0) begin
        m_acc = 0; m_cnt = 0; m_lvl = 0; m_dac = 0;
      end else if (m_ctrl / 2 == 0) begin
        s = m_acc + m_mix;
        m_dac = (s >= 64) ? 1 : 0;
        m_acc = s % 64;
      end else begin
        m_dac = (m_cnt < m_lvl) ? 1 : 0;
        if (m_cnt == 63) m_lvl = m_mix;
        m_cnt = (m_cnt + 1) % 64;
      end
      if (sample_en) begin
        q_val.push_back((sq0 ? m_vol[0] : 0) + (sq1 ? m_vol[1] : 0)
                        + (int'(tri_in) * m_vol[2]) / 16);
        q_due.push_back(cyc + 1);
      end
      if (cfg_wr) begin
        if (cfg_addr == 2'd3) m_ctrl = int'(cfg_d) % 4;
        else m_vol[cfg_addr] = int'(cfg_d);
      end
      m_mix = nmix;
    end
  end

  always @(negedge clk) begin
    if (m_on == 1) begin
      total++;
      if (int'(mix) != m_mix) begin
        bad++;
        $display("FAIL model_mix t=%0t got=%0d exp=%0d", $time, mix, m_mix);
      end
      total++;
      if (int'(dac) != m_dac) begin
        bad++;
        $display("FAIL model_dac t=%0t got=%0d exp=%0d", $time, dac, m_dac);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg(input int a, input int d);
    cfg_wr = 1'b1; cfg_addr = 2'(a); cfg_d = 4'(d);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic strobe(input bit s0, input bit s1, input int t);
    sq0 = s0; sq1 = s1; tri_in = 4'(t); sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic ones64(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      n += int'(dac);
    end
  endtask

  initial begin
    int n, rises, falls;
    bit prev;
    rst = 1'b1; sample_en = 1'b1; sq0 = 1'b1; sq1 = 1'b1; tri_in = 4'd15;
    cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_d = 4'd0;
    repeat (2) tick();
    rst = 1'b0; sample_en = 1'b0; cfg_wr = 1'b0;
    chk("reset_mix", int'(mix), 0);
    chk("reset_dac", int'(dac), 0);

    // Reset volumes are all 15: 15 + 15 + (15*15)>>4 = 44
    strobe(1, 1, 15);
    tick();
    chk("reset_vols_mix", int'(mix), 44);

    strobe(1, 0, 0);
    chk("latency_hold", int'(mix), 44);
    tick();
    chk("sq0_mix", int'(mix), 15);
    ones64(n);
    chk("sd_ones_15", n, 15);

    cfg(2, 5);
    strobe(0, 0, 8);
    tick();
    chk("tri_mix_2", int'(mix), 2);
    cfg(2, 15);
    strobe(1, 1, 15);
    tick();
    chk("full_mix_44", int'(mix), 44);
    ones64(n);
    chk("sd_ones_44", n, 44);

    cfg(3, 3);
    repeat (70) tick();
    ones64(n);
    chk("pwm_ones_44", n, 44);
    rises = 0; falls = 0; prev = dac;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (!prev && dac) rises++;
      if (prev && !dac) falls++;
      prev = dac;
    end
    chk("pwm_rises", rises, 1);
    chk("pwm_falls", falls, 1);
    repeat (17) tick();
    cfg(0, 10);
    strobe(1, 0, 0);
    tick();
    chk("pwm_mix_10", int'(mix), 10);
    repeat (130) tick();
    ones64(n);
    chk("pwm_ones_10", n, 10);

    cfg(3, 1);
    cfg(0, 15);
    cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_d = 4'd0;
    sq0 = 1'b1; sq1 = 1'b0; tri_in = 4'd0; sample_en = 1'b1;
    tick();
    cfg_wr = 1'b0; sample_en = 1'b0;
    tick();
    chk("same_cycle_old_vol", int'(mix), 15);
    strobe(1, 0, 0);
    tick();
    chk("next_sample_new_vol", int'(mix), 0);

    cfg(3, 0);
    for (int i = 0; i < 4; i++) begin
      chk("disabled_dac", int'(dac), 0);
      tick();
    end
    cfg(2, 4);
    cfg(0, 15);
    cfg(1, 15);
    strobe(1, 1, 8);
    tick();
    chk("mix_32", int'(mix), 32);
    cfg(3, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sd_alternate", int'(dac), i % 2);
    end

    // Reset with a sample in flight and a same-cycle write: all discarded
    strobe(1, 1, 15);
    rst = 1'b1; sample_en = 1'b1; cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_d = 4'd3;
    tick();
    rst = 1'b0; sample_en = 1'b0; cfg_wr = 1'b0;
    repeat (3) tick();
    chk("rst_discard_mix", int'(mix), 0);
    strobe(1, 1, 15);
    tick();
    chk("rst_vols_mix", int'(mix), 44);
    ones64(n);
    chk("rst_ctrl_sd_ones", n, 44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
